// File: rtl/bus_receive_fifo_if.sv
`default_nettype none
// ============================================================================
// bus_receive_fifo_if : bus-side and consumer-side signals of bus_receive_fifo
// Revision 1.0
// ============================================================================
interface bus_receive_fifo_if #(
   parameter int WIDTH = 16,
   parameter int PTR_W = 2
);
   logic [WIDTH-1:0] busIn;
   logic             busValid;
   logic             busBusy;
   logic [WIDTH-1:0] dataOut;
   logic             dataValid;
   logic             dataReady;
   logic [PTR_W:0]   count;
   logic             overflow;
   logic             clearOverflow;

   modport master (
      output busIn, busValid, dataReady, clearOverflow,
      input  busBusy, dataOut, dataValid, count, overflow
   );

   modport slave (
      input  busIn, busValid, dataReady, clearOverflow,
      output busBusy, dataOut, dataValid, count, overflow
   );
endinterface
`default_nettype wire

// File: rtl/bus_receive_fifo.sv
`default_nettype none
// ============================================================================
// bus_receive_fifo : samples the shared bus into a show-ahead FIFO with a
//                    valid/ready consumer port, backpressure and sticky drop flag
// Revision 1.0
// ============================================================================
module bus_receive_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4,
   parameter int PTR_W = 2
) (
   input  wire logic         clk,
   input  wire logic         reset_n,
   bus_receive_fifo_if.slave bus
);
   localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             overflow_q, overflow_d;

   logic full, empty, push, pop, drop;

   always_comb begin
      full  = (count_q == FULL_COUNT);
      empty = (count_q == '0);
      pop   = !empty && bus.dataReady;
      // A pop in the same cycle frees the slot, so a full FIFO can still accept.
      push  = bus.busValid && (!full || pop);
      drop  = bus.busValid && full && !pop;

      mem_d      = mem_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = overflow_q;

      if (push) begin
         mem_d[wr_ptr_q] = bus.busIn;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + COUNT_ONE;
         2'b01:   count_d = count_q - COUNT_ONE;
         default: count_d = count_q;
      endcase

      // Set is evaluated last so a drop wins over a simultaneous clear.
      if (bus.clearOverflow) begin
         overflow_d = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         mem_q      <= mem_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   assign bus.busBusy   = (count_q == FULL_COUNT);
   assign bus.dataValid = (count_q != '0);
   assign bus.dataOut   = mem_q[rd_ptr_q];
   assign bus.count     = count_q;
   assign bus.overflow  = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_receive_fifo.sv
`default_nettype none
// ============================================================================
// tb_bus_receive_fifo : directed self-checking bench for bus_receive_fifo
// Revision 1.0
// ============================================================================
module tb_bus_receive_fifo;
   logic clk;
   logic reset_n;
   int   pass_cnt;
   int   total_cnt;

   bus_receive_fifo_if #(.WIDTH(16), .PTR_W(2)) bus_if ();

   bus_receive_fifo #(.WIDTH(16), .DEPTH(4), .PTR_W(2)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one edge; inputs are driven and outputs sampled 1ns after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [15:0] w);
      bus_if.busValid = 1'b1;
      bus_if.busIn    = w;
      step();
      bus_if.busValid = 1'b0;
      bus_if.busIn    = 'z;
   endtask

   task automatic test_reset();
      for (int i = 1; i <= 5; i++) push_word(16'(i));
      bus_if.dataReady = 1'b1;
      step();
      bus_if.dataReady = 1'b0;
      total_cnt++; if (bus_if.count !== 3'd3) $display("FAIL pre_reset_count actual=%0d expected=3", bus_if.count); else pass_cnt++;
      total_cnt++; if (bus_if.overflow !== 1'b1) $display("FAIL pre_reset_overflow actual=%b expected=1", bus_if.overflow); else pass_cnt++;
      #2 reset_n = 1'b0;
      #1;
      total_cnt++; if (bus_if.count !== 3'd0) $display("FAIL reset_count actual=%0d expected=0", bus_if.count); else pass_cnt++;
      total_cnt++; if (bus_if.dataValid !== 1'b0) $display("FAIL reset_dataValid actual=%b expected=0", bus_if.dataValid); else pass_cnt++;
      total_cnt++; if (bus_if.busBusy !== 1'b0) $display("FAIL reset_busBusy actual=%b expected=0", bus_if.busBusy); else pass_cnt++;
      total_cnt++; if (bus_if.overflow !== 1'b0) $display("FAIL reset_overflow actual=%b expected=0", bus_if.overflow); else pass_cnt++;
      total_cnt++; if (bus_if.dataOut !== 16'h0000) $display("FAIL reset_dataOut actual=%h expected=0000", bus_if.dataOut); else pass_cnt++;
      @(negedge clk);
      reset_n = 1'b1;
      step();
      total_cnt++; if (bus_if.count !== 3'd0) $display("FAIL post_reset_count actual=%0d expected=0", bus_if.count); else pass_cnt++;
   endtask

   task automatic test_single_push();
      push_word(16'hA5C3);
      total_cnt++; if (bus_if.dataValid !== 1'b1) $display("FAIL single_dataValid actual=%b expected=1", bus_if.dataValid); else pass_cnt++;
      total_cnt++; if (bus_if.dataOut !== 16'hA5C3) $display("FAIL single_dataOut actual=%h expected=a5c3", bus_if.dataOut); else pass_cnt++;
      total_cnt++; if (bus_if.count !== 3'd1) $display("FAIL single_count actual=%0d expected=1", bus_if.count); else pass_cnt++;
      bus_if.dataReady = 1'b1;
      step();
      bus_if.dataReady = 1'b0;
      total_cnt++; if (bus_if.dataValid !== 1'b0) $display("FAIL single_pop_dataValid actual=%b expected=0", bus_if.dataValid); else pass_cnt++;
      total_cnt++; if (bus_if.count !== 3'd0) $display("FAIL single_pop_count actual=%0d expected=0", bus_if.count); else pass_cnt++;
   endtask

   task automatic test_fill_drop();
      for (int i = 1; i <= 4; i++) push_word(16'(i));
      total_cnt++; if (bus_if.count !== 3'd4) $display("FAIL fill_count actual=%0d expected=4", bus_if.count); else pass_cnt++;
      total_cnt++; if (bus_if.busBusy !== 1'b1) $display("FAIL fill_busBusy actual=%b expected=1", bus_if.busBusy); else pass_cnt++;
      total_cnt++; if (bus_if.overflow !== 1'b0) $display("FAIL fill_overflow actual=%b expected=0", bus_if.overflow); else pass_cnt++;
      push_word(16'h0005);
      total_cnt++; if (bus_if.overflow !== 1'b1) $display("FAIL drop_overflow actual=%b expected=1", bus_if.overflow); else pass_cnt++;
      total_cnt++; if (bus_if.count !== 3'd4) $display("FAIL drop_count actual=%0d expected=4", bus_if.count); else pass_cnt++;
      bus_if.dataReady = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         total_cnt++; if (bus_if.dataOut !== 16'(i)) $display("FAIL drain_word%0d actual=%h expected=%h", i, bus_if.dataOut, 16'(i)); else pass_cnt++;
         step();
      end
      bus_if.dataReady = 1'b0;
      total_cnt++; if (bus_if.count !== 3'd0) $display("FAIL drain_count actual=%0d expected=0", bus_if.count); else pass_cnt++;
      bus_if.clearOverflow = 1'b1;
      step();
      bus_if.clearOverflow = 1'b0;
      total_cnt++; if (bus_if.overflow !== 1'b0) $display("FAIL clear_overflow actual=%b expected=0", bus_if.overflow); else pass_cnt++;
   endtask

   task automatic test_full_push_pop();
      for (int i = 1; i <= 4; i++) push_word(16'(i));
      bus_if.dataReady = 1'b1;
      push_word(16'h0005);
      total_cnt++; if (bus_if.overflow !== 1'b0) $display("FAIL fullpp_overflow actual=%b expected=0", bus_if.overflow); else pass_cnt++;
      total_cnt++; if (bus_if.count !== 3'd4) $display("FAIL fullpp_count actual=%0d expected=4", bus_if.count); else pass_cnt++;
      for (int i = 2; i <= 5; i++) begin
         total_cnt++; if (bus_if.dataOut !== 16'(i)) $display("FAIL fullpp_word%0d actual=%h expected=%h", i, bus_if.dataOut, 16'(i)); else pass_cnt++;
         step();
      end
      bus_if.dataReady = 1'b0;
      total_cnt++; if (bus_if.count !== 3'd0) $display("FAIL fullpp_drain_count actual=%0d expected=0", bus_if.count); else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      bus_if.dataReady = 1'b1;
      bus_if.busValid  = 1'b1;
      for (int i = 0; i < 10; i++) begin
         bus_if.busIn = 16'h0100 + 16'(i);
         step();
         total_cnt++; if (bus_if.dataOut !== 16'h0100 + 16'(i)) $display("FAIL b2b_word%0d actual=%h expected=%h", i, bus_if.dataOut, 16'h0100 + 16'(i)); else pass_cnt++;
         total_cnt++; if (bus_if.count !== 3'd1) $display("FAIL b2b_count%0d actual=%0d expected=1", i, bus_if.count); else pass_cnt++;
      end
      bus_if.busValid = 1'b0;
      bus_if.busIn    = 'z;
      step();
      bus_if.dataReady = 1'b0;
      total_cnt++; if (bus_if.count !== 3'd0) $display("FAIL b2b_final_count actual=%0d expected=0", bus_if.count); else pass_cnt++;
      total_cnt++; if (bus_if.overflow !== 1'b0) $display("FAIL b2b_overflow actual=%b expected=0", bus_if.overflow); else pass_cnt++;
   endtask

   task automatic test_sticky_z();
      push_word(16'h1234);
      for (int i = 0; i < 5; i++) begin
         step();
         total_cnt++; if (bus_if.count !== 3'd1) $display("FAIL z_count%0d actual=%0d expected=1", i, bus_if.count); else pass_cnt++;
      end
      total_cnt++; if (bus_if.dataOut !== 16'h1234) $display("FAIL z_dataOut actual=%h expected=1234", bus_if.dataOut); else pass_cnt++;
      for (int i = 0; i < 4; i++) push_word(16'h2000 + 16'(i));
      total_cnt++; if (bus_if.overflow !== 1'b1) $display("FAIL sticky_set actual=%b expected=1", bus_if.overflow); else pass_cnt++;
      step();
      total_cnt++; if (bus_if.overflow !== 1'b1) $display("FAIL sticky_hold actual=%b expected=1", bus_if.overflow); else pass_cnt++;
      bus_if.clearOverflow = 1'b1;
      step();
      bus_if.clearOverflow = 1'b0;
      total_cnt++; if (bus_if.overflow !== 1'b0) $display("FAIL sticky_clear actual=%b expected=0", bus_if.overflow); else pass_cnt++;
      bus_if.clearOverflow = 1'b1;
      push_word(16'hDEAD);
      bus_if.clearOverflow = 1'b0;
      total_cnt++; if (bus_if.overflow !== 1'b1) $display("FAIL set_wins actual=%b expected=1", bus_if.overflow); else pass_cnt++;
      total_cnt++; if (bus_if.count !== 3'd4) $display("FAIL set_wins_count actual=%0d expected=4", bus_if.count); else pass_cnt++;
      total_cnt++; if (bus_if.dataOut !== 16'h1234) $display("FAIL set_wins_head actual=%h expected=1234", bus_if.dataOut); else pass_cnt++;
   endtask

   initial begin
      pass_cnt             = 0;
      total_cnt            = 0;
      reset_n              = 1'b0;
      bus_if.busIn         = 'z;
      bus_if.busValid      = 1'b0;
      bus_if.dataReady     = 1'b0;
      bus_if.clearOverflow = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      step();
      test_reset();
      test_single_push();
      test_fill_drop();
      test_full_push_pop();
      test_back_to_back();
      test_sticky_z();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
`default_nettype wire
